// File: rtl/cluster_noc_pkg.sv
// Shared definitions for the cluster NoC (upstream and downstream halves).
// Provides the cluster-index width helper, the NHI ID width rule and the
// default AXI request/response structs at the cluster and NHI ID widths.
package cluster_noc_pkg;

  // Width of a cluster index; never zero, so a single cluster still gets one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // NHI IDs are the cluster ID with the issuing cluster index prepended.
  function automatic int unsigned nhi_id_width(input int unsigned cl_id_w,
                                               input int unsigned num_cl);
    return cl_id_w + idx_width(num_cl);
  endfunction

  localparam int unsigned NUM_CL   = 4;
  localparam int unsigned CL_ID_W  = 6;
  localparam int unsigned NHI_ID_W = nhi_id_width(CL_ID_W, NUM_CL);
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = DATA_W / 8;

  typedef struct packed {
    logic [CL_ID_W-1:0] id;
    logic [ADDR_W-1:0]  addr;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic [5:0]         atop;
  } cl_aw_t;

  typedef struct packed {
    logic [NHI_ID_W-1:0] id;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [5:0]          atop;
  } nhi_aw_t;

  typedef struct packed {
    logic [CL_ID_W-1:0] id;
    logic [ADDR_W-1:0]  addr;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
  } cl_ar_t;

  typedef struct packed {
    logic [NHI_ID_W-1:0] id;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } nhi_ar_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_t;

  typedef struct packed {
    logic [CL_ID_W-1:0] id;
    logic [1:0]         resp;
  } cl_b_t;

  typedef struct packed {
    logic [NHI_ID_W-1:0] id;
    logic [1:0]          resp;
  } nhi_b_t;

  typedef struct packed {
    logic [CL_ID_W-1:0] id;
    logic [DATA_W-1:0]  data;
    logic [1:0]         resp;
    logic               last;
  } cl_r_t;

  typedef struct packed {
    logic [NHI_ID_W-1:0] id;
    logic [DATA_W-1:0]   data;
    logic [1:0]          resp;
    logic                last;
  } nhi_r_t;

  typedef struct packed {
    cl_aw_t aw;
    logic   aw_valid;
    w_t     w;
    logic   w_valid;
    logic   b_ready;
    cl_ar_t ar;
    logic   ar_valid;
    logic   r_ready;
  } cl_req_t;

  typedef struct packed {
    logic  aw_ready;
    logic  ar_ready;
    logic  w_ready;
    logic  b_valid;
    cl_b_t b;
    logic  r_valid;
    cl_r_t r;
  } cl_resp_t;

  typedef struct packed {
    nhi_aw_t aw;
    logic    aw_valid;
    w_t      w;
    logic    w_valid;
    logic    b_ready;
    nhi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } nhi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    nhi_b_t b;
    logic   r_valid;
    nhi_r_t r;
  } nhi_resp_t;

endpackage

// File: rtl/cluster_noc_rr_arb.sv
// Lockable round-robin arbiter.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : per-requester request
//   en_i         : output may be offered (e.g. downstream has room)
//   hs_i         : handshake of the granted request this cycle
//   valid_o      : a grant is being offered
//   gnt_o, idx_o : one-hot grant and its index
// Once a grant has been offered it stays locked until its handshake, so the
// selected payload cannot change under a stall. The pointer moves to the
// requester after the winner only on a handshake.
module cluster_noc_rr_arb #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            en_i,
  input  logic            hs_i,
  output logic            valid_o,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] lock_idx_q;
  logic            lock_q;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] cand;
  logic            found;

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] i);
    return (32'(i) >= N - 1) ? '0 : i + 1'b1;
  endfunction

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    pick_idx = ptr_q;
    found    = 1'b0;
    cand     = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  assign idx_o   = lock_q ? lock_idx_q : pick_idx;
  assign valid_o = en_i & (lock_q ? req_i[lock_idx_q] : found);

  always_comb begin
    gnt_o        = '0;
    gnt_o[idx_o] = valid_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (hs_i) begin
      lock_q <= 1'b0;
      ptr_q  <= wrap_inc(idx_o);
    end else if (valid_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= idx_o;
    end
  end

endmodule

// File: rtl/cluster_noc_upstream.sv
// Upstream half of the cluster NoC: merges the AXI master ports of all
// clusters onto the single NHI master port.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   cl_req_i     : per-cluster AXI master requests
//   cl_resp_o    : per-cluster AXI responses
//   nhi_req_o    : merged AXI request toward host/L2 (IDs widened by index)
//   nhi_resp_i   : AXI response from NHI, routed back by the ID prefix
// AW and AR are arbitrated independently round-robin. W bursts follow AW grant
// order through a small index FIFO. All paths are combinational.
module cluster_noc_upstream #(
  parameter int unsigned NumClusters = 4,
  parameter int unsigned ClIdWidth   = 6,
  parameter int unsigned IdxWidth    = cluster_noc_pkg::idx_width(NumClusters),
  parameter int unsigned NHIIdWidth  = ClIdWidth + IdxWidth,
  parameter int unsigned MaxWTrans   = 8,
  parameter type cl_req_t   = cluster_noc_pkg::cl_req_t,
  parameter type cl_resp_t  = cluster_noc_pkg::cl_resp_t,
  parameter type nhi_req_t  = cluster_noc_pkg::nhi_req_t,
  parameter type nhi_resp_t = cluster_noc_pkg::nhi_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  cl_req_t   cl_req_i  [NumClusters],
  output cl_resp_t  cl_resp_o [NumClusters],
  output nhi_req_t  nhi_req_o,
  input  nhi_resp_t nhi_resp_i
);

  import cluster_noc_pkg::*;

  localparam int unsigned PtrW = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxWTrans + 1);

  logic [NumClusters-1:0] aw_req, ar_req, aw_gnt, ar_gnt;
  logic [IdxWidth-1:0]    aw_idx, ar_idx;
  logic                   aw_valid, ar_valid, aw_hs, ar_hs, aw_en;

  logic [IdxWidth-1:0]    wfifo_mem [MaxWTrans];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        cnt_q;
  logic                   fifo_empty, fifo_full, pop_at_full;
  logic [IdxWidth-1:0]    fifo_head;
  logic [IdxWidth-1:0]    w_sel;
  logic                   w_sel_valid, w_valid, w_push, w_pop;

  logic [IdxWidth-1:0]    b_idx, r_idx;
  logic                   b_idx_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) >= MaxWTrans - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NumClusters; i++) begin
      aw_req[i] = cl_req_i[i].aw_valid;
      ar_req[i] = cl_req_i[i].ar_valid;
    end
  end

  // W order FIFO state
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CntW'(MaxWTrans));
  assign fifo_head  = wfifo_mem[rd_ptr_q];

  // A full FIFO still accepts an AW when the head burst finishes this cycle.
  // Computed from the stored head only, so it never depends on the AW handshake.
  assign pop_at_full = fifo_full & cl_req_i[fifo_head].w_valid
                     & cl_req_i[fifo_head].w.last & nhi_resp_i.w_ready;
  assign aw_en       = ~rst_i & (~fifo_full | pop_at_full);

  cluster_noc_rr_arb #(.N(NumClusters), .IdxW(IdxWidth)) i_aw_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (aw_req),
    .en_i    (aw_en),
    .hs_i    (aw_hs),
    .valid_o (aw_valid),
    .gnt_o   (aw_gnt),
    .idx_o   (aw_idx)
  );

  cluster_noc_rr_arb #(.N(NumClusters), .IdxW(IdxWidth)) i_ar_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (ar_req),
    .en_i    (~rst_i),
    .hs_i    (ar_hs),
    .valid_o (ar_valid),
    .gnt_o   (ar_gnt),
    .idx_o   (ar_idx)
  );

  assign aw_hs = aw_valid & nhi_resp_i.aw_ready;
  assign ar_hs = ar_valid & nhi_resp_i.ar_ready;

  // With an empty FIFO the cluster whose AW is handshaking now owns W.
  assign w_sel       = fifo_empty ? aw_idx : fifo_head;
  assign w_sel_valid = ~fifo_empty | aw_hs;
  assign w_valid     = w_sel_valid & cl_req_i[w_sel].w_valid;
  assign w_push      = aw_hs;
  assign w_pop       = w_valid & nhi_resp_i.w_ready & cl_req_i[w_sel].w.last;

  assign b_idx    = nhi_resp_i.b.id[NHIIdWidth-1 -: IdxWidth];
  assign r_idx    = nhi_resp_i.r.id[NHIIdWidth-1 -: IdxWidth];
  assign b_idx_ok = (32'(b_idx) < NumClusters);

  always_comb begin
    nhi_req_o          = '0;
    nhi_req_o.aw_valid = aw_valid;
    nhi_req_o.aw.id    = {aw_idx, cl_req_i[aw_idx].aw.id};
    nhi_req_o.aw.addr  = cl_req_i[aw_idx].aw.addr;
    nhi_req_o.aw.len   = cl_req_i[aw_idx].aw.len;
    nhi_req_o.aw.size  = cl_req_i[aw_idx].aw.size;
    nhi_req_o.aw.burst = cl_req_i[aw_idx].aw.burst;
    nhi_req_o.aw.atop  = cl_req_i[aw_idx].aw.atop;
    nhi_req_o.ar_valid = ar_valid;
    nhi_req_o.ar.id    = {ar_idx, cl_req_i[ar_idx].ar.id};
    nhi_req_o.ar.addr  = cl_req_i[ar_idx].ar.addr;
    nhi_req_o.ar.len   = cl_req_i[ar_idx].ar.len;
    nhi_req_o.ar.size  = cl_req_i[ar_idx].ar.size;
    nhi_req_o.ar.burst = cl_req_i[ar_idx].ar.burst;
    nhi_req_o.w        = cl_req_i[w_sel].w;
    nhi_req_o.w_valid  = w_valid;
    // Responses addressed to a nonexistent cluster are drained.
    nhi_req_o.b_ready  = 1'b1;
    nhi_req_o.r_ready  = 1'b1;
    for (int i = 0; i < NumClusters; i++) begin
      if (b_idx == IdxWidth'(i)) nhi_req_o.b_ready = cl_req_i[i].b_ready;
      if (r_idx == IdxWidth'(i)) nhi_req_o.r_ready = cl_req_i[i].r_ready;
    end
  end

  always_comb begin
    for (int i = 0; i < NumClusters; i++) begin
      cl_resp_o[i]          = '0;
      cl_resp_o[i].aw_ready = aw_gnt[i] & nhi_resp_i.aw_ready;
      cl_resp_o[i].ar_ready = ar_gnt[i] & nhi_resp_i.ar_ready;
      cl_resp_o[i].w_ready  = w_sel_valid & (w_sel == IdxWidth'(i)) & nhi_resp_i.w_ready;
      cl_resp_o[i].b_valid  = nhi_resp_i.b_valid & (b_idx == IdxWidth'(i));
      cl_resp_o[i].b.id     = nhi_resp_i.b.id[ClIdWidth-1:0];
      cl_resp_o[i].b.resp   = nhi_resp_i.b.resp;
      cl_resp_o[i].r_valid  = nhi_resp_i.r_valid & (r_idx == IdxWidth'(i));
      cl_resp_o[i].r.id     = nhi_resp_i.r.id[ClIdWidth-1:0];
      cl_resp_o[i].r.data   = nhi_resp_i.r.data;
      cl_resp_o[i].r.resp   = nhi_resp_i.r.resp;
      cl_resp_o[i].r.last   = nhi_resp_i.r.last;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (w_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) wfifo_mem[wr_ptr_q] <= aw_idx;
  end

  // Clusters never issue atomics, and every B must belong to a real cluster.
  assert property (@(posedge clk_i) disable iff (rst_i)
    nhi_req_o.aw_valid |-> (nhi_req_o.aw.atop == '0));
  assert property (@(posedge clk_i) disable iff (rst_i)
    nhi_resp_i.b_valid |-> b_idx_ok);

endmodule
